// File: rtl/i2c_master_ctrl.sv
// I2C master transaction sequencer: bus check, START, address/data byte hand-off to an
// external byte timer, STOP. Optional repeated-start ending under I2C_REPEATED_START_EN.
module i2c_master_ctrl (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        go_i,
  input  logic        rw_i,
  input  logic [6:0]  addr_i,
  input  logic [5:0]  byte_count_i,
`ifdef I2C_REPEATED_START_EN
  input  logic        rep_start_i,
`endif
  input  logic [31:0] clock_div_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        timer_active_o,
  output logic        direction_o,
  output logic        should_nack_o,
  input  logic        timer_scl_i,
  input  logic        shift_strobe_i,
  input  logic        byte_complete_i,
  input  logic        ack_gen_i,
  input  logic        ack_i,
  input  logic        abort_i,
  input  logic        sda_sync_i,
  input  logic        scl_sync_i,
  output logic        sda_out_o,
  output logic        scl_out_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_err_o,
  output logic        arb_err_o,
  output logic [3:0]  state_o
);

  // Write data: tx_ready_o is high only in LOAD of a write; a byte transfers on the
  // cycle where tx_valid_i and tx_ready_o are both high. rx_valid_o is a single-cycle
  // strobe with no back-pressure.

  typedef enum logic [3:0] {
    S_IDLE, S_BUS_CHK, S_START_A, S_START_B, S_ADDR, S_LOAD, S_DATA,
    S_STOP_A, S_STOP_B, S_STOP_C, S_DONE, S_ERR, S_RS_A, S_RS_B
  } state_t;

  state_t      state_q, state_d, end_state;
  logic [31:0] cnt_q, cnt_d, div;
  logic        cnt_en, phase_last;
  logic [6:0]  addr_q;
  logic        rw_q;
  logic [5:0]  remaining_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bit_cnt_q;
  logic        rel_q;
  logic        scl_prev_q;
  logic        nack_err_q, arb_err_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        go_acc, load_addr, load_tx, scl_fall;
  logic        rep_q, hold_q;

  assign div        = (clock_div_i == 32'd0) ? 32'd1 : clock_div_i;
  assign phase_last = (cnt_q + 32'd1 == div);
  assign scl_fall   = scl_prev_q & ~scl_sync_i;
  assign go_acc     = (state_q == S_IDLE) && go_i && !abort_i;
  assign end_state  = rep_q ? S_RS_A : S_STOP_A;
  assign load_addr  = (state_q == S_START_B) && (state_d == S_ADDR);
  assign load_tx    = (state_q == S_LOAD) && (state_d == S_DATA) && !rw_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE:    if (go_i) state_d = hold_q ? S_START_A : S_BUS_CHK;
      S_BUS_CHK: if (sda_sync_i && scl_sync_i) begin
                   cnt_en = 1'b1;
                   if (phase_last) state_d = S_START_A;
                 end
      S_START_A: begin cnt_en = 1'b1; if (phase_last) state_d = S_START_B; end
      S_START_B: begin cnt_en = 1'b1; if (phase_last) state_d = S_ADDR; end
      S_ADDR:    if (byte_complete_i) begin
                   if (ack_i)                   state_d = S_STOP_A;
                   else if (remaining_q == 6'd0) state_d = end_state;
                   else                          state_d = S_LOAD;
                 end
      S_LOAD:    if (rw_q || tx_valid_i) state_d = S_DATA;
      S_DATA:    if (byte_complete_i) begin
                   if (!rw_q && ack_i)           state_d = S_STOP_A;
                   else if (remaining_q <= 6'd1) state_d = end_state;
                   else                          state_d = S_LOAD;
                 end
      S_STOP_A:  begin cnt_en = 1'b1; if (phase_last) state_d = S_STOP_B; end
      // SCL may be stretched by a slave; only count once the line is seen high
      S_STOP_B:  if (scl_sync_i) begin
                   cnt_en = 1'b1;
                   if (phase_last) state_d = S_STOP_C;
                 end
      S_STOP_C:  begin cnt_en = 1'b1; if (phase_last) state_d = S_DONE; end
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      S_RS_A:    begin cnt_en = 1'b1; if (phase_last) state_d = S_RS_B; end
      S_RS_B:    if (scl_sync_i) begin
                   cnt_en = 1'b1;
                   if (phase_last) state_d = S_DONE;
                 end
      default:   state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_ERR;
    if (state_d != state_q) cnt_d = 32'd0;
    else if (cnt_en)        cnt_d = cnt_q + 32'd1;
    else                    cnt_d = 32'd0;
  end

  always_comb begin
    timer_active_o = 1'b0;
    direction_o    = 1'b1;
    should_nack_o  = 1'b0;
    tx_ready_o     = 1'b0;
    sda_out_o      = 1'b1;
    scl_out_o      = 1'b1;
    case (state_q)
      S_IDLE, S_DONE: if (hold_q) scl_out_o = 1'b0;
      S_START_A: sda_out_o = 1'b0;
      S_START_B: begin sda_out_o = 1'b0; scl_out_o = 1'b0; end
      S_ADDR: begin
        timer_active_o = 1'b1;
        sda_out_o      = rel_q | shreg_q[7];
      end
      S_LOAD: begin
        scl_out_o  = 1'b0;
        tx_ready_o = !rw_q;
      end
      S_DATA: begin
        timer_active_o = 1'b1;
        direction_o    = !rw_q;
        should_nack_o  = rw_q && (remaining_q == 6'd1);
        sda_out_o      = rw_q ? !ack_gen_i : (rel_q | shreg_q[7]);
      end
      S_STOP_A: begin sda_out_o = 1'b0; scl_out_o = 1'b0; end
      S_STOP_B: sda_out_o = 1'b0;
      S_RS_A:   scl_out_o = 1'b0;
      default: ;
    endcase
    if (timer_active_o) scl_out_o = timer_scl_i;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      remaining_q <= 6'd0;
      shreg_q     <= 8'hFF;
      bit_cnt_q   <= 3'd0;
      rel_q       <= 1'b0;
      scl_prev_q  <= 1'b1;
      nack_err_q  <= 1'b0;
      arb_err_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
    end else begin
      scl_prev_q <= scl_sync_i;
      rx_valid_q <= 1'b0;
      if (go_acc) begin
        addr_q      <= addr_i;
        rw_q        <= rw_i;
        remaining_q <= byte_count_i;
        nack_err_q  <= 1'b0;
        arb_err_q   <= 1'b0;
      end
      if (abort_i) arb_err_q <= 1'b1;
      if (load_addr) begin
        shreg_q   <= {addr_q, rw_q};
        bit_cnt_q <= 3'd0;
        rel_q     <= 1'b0;
      end else if (load_tx) begin
        shreg_q   <= tx_data_i;
        bit_cnt_q <= 3'd0;
        rel_q     <= 1'b0;
      end else if (state_q == S_LOAD) begin
        bit_cnt_q <= 3'd0;
        rel_q     <= 1'b0;
      end else if (timer_active_o && shift_strobe_i) begin
        shreg_q <= direction_o ? {shreg_q[6:0], 1'b1} : {shreg_q[6:0], sda_sync_i};
        if (bit_cnt_q != 3'd7) bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      // Seven data bits shifted out; release SDA on the falling edge that opens the ack bit
      if (timer_active_o && direction_o && bit_cnt_q == 3'd7 && scl_fall) rel_q <= 1'b1;
      if (!abort_i && byte_complete_i) begin
        if (state_q == S_ADDR && ack_i) nack_err_q <= 1'b1;
        if (state_q == S_DATA) begin
          remaining_q <= remaining_q - 6'd1;
          if (rw_q) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= shreg_q;
          end else if (ack_i) begin
            nack_err_q <= 1'b1;
          end
        end
      end
    end
  end

`ifdef I2C_REPEATED_START_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rep_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      if (go_acc) begin
        rep_q  <= rep_start_i;
        hold_q <= 1'b0;
      end
      if (state_q == S_RS_B && state_d == S_DONE) hold_q <= 1'b1;
      if (abort_i) hold_q <= 1'b0;
    end
  end
`else
  assign rep_q  = 1'b0;
  assign hold_q = 1'b0;
`endif

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign nack_err_o = nack_err_q;
  assign arb_err_o  = arb_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a small byte-timer/slave model driven from tasks.
module tb_i2c_master_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        go = 1'b0, rw = 1'b0;
  logic [6:0]  addr = 7'd0;
  logic [5:0]  byte_count = 6'd0;
`ifdef I2C_REPEATED_START_EN
  logic        rep_start = 1'b0;
`endif
  logic [31:0] clock_div = 32'd4;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, timer_active, direction, should_nack;
  logic        timer_scl = 1'b0, shift_strobe = 1'b0, byte_complete = 1'b0;
  logic        ack_gen = 1'b0, ack = 1'b0, abort = 1'b0;
  logic        sda_sync, scl_sync, sda_out, scl_out;
  logic        busy, done, nack_err, arb_err;
  logic [3:0]  state_dbg;
  logic        slave_sda = 1'b1, force_sda_low = 1'b0;

  assign sda_sync = sda_out & slave_sda & ~force_sda_low;
  assign scl_sync = scl_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  i2c_master_ctrl dut (
    .clk(clk), .n_rst(n_rst), .go_i(go), .rw_i(rw), .addr_i(addr),
    .byte_count_i(byte_count),
`ifdef I2C_REPEATED_START_EN
    .rep_start_i(rep_start),
`endif
    .clock_div_i(clock_div), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .timer_active_o(timer_active), .direction_o(direction), .should_nack_o(should_nack),
    .timer_scl_i(timer_scl), .shift_strobe_i(shift_strobe), .byte_complete_i(byte_complete),
    .ack_gen_i(ack_gen), .ack_i(ack), .abort_i(abort),
    .sda_sync_i(sda_sync), .scl_sync_i(scl_sync), .sda_out_o(sda_out), .scl_out_o(scl_out),
    .busy_o(busy), .done_o(done), .nack_err_o(nack_err), .arb_err_o(arb_err),
    .state_o(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue go and check the bus-idle qualification window (clock_div = 4).
  task automatic start_txn(input logic r, input logic [6:0] a, input logic [5:0] bc);
    rw = r; addr = a; byte_count = bc; go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_after_go", busy, 1);
    repeat (3) tick();
    chk("bus_chk_no_early_start", sda_out, 1);
    tick();
    chk("start_a_lines", {sda_out, scl_out}, 2'b01);
  endtask

  // Byte-timer + slave model: 9 SCL periods of 2 low / 2 high cycles, then byte_complete.
  task automatic run_byte(input logic is_tx, input logic [7:0] slave_byte, input logic ack_val,
                          output logic [7:0] seen, output logic ack_sda, output logic sn_seen);
    int n;
    n = 0;
    while (timer_active !== 1'b1 && n < 300) begin tick(); n++; end
    chk("timer_active_wait", timer_active, 1);
    seen = 8'd0; ack_sda = 1'b0; sn_seen = 1'b0;
    for (int b = 0; b < 9; b++) begin
      timer_scl = 1'b0;
      shift_strobe = is_tx && (b >= 1) && (b <= 7);
      if (!is_tx) begin
        slave_sda = (b < 8) ? slave_byte[7-b] : 1'b1;
        ack_gen   = (b == 8) && !should_nack;
      end
      sn_seen = sn_seen | should_nack;
      tick();
      shift_strobe = 1'b0;
      tick();
      timer_scl = 1'b1;
      shift_strobe = !is_tx && (b < 8);
      tick();
      shift_strobe = 1'b0;
      if (b < 8) seen[7-b] = sda_out;
      else       ack_sda = sda_out;
      tick();
    end
    timer_scl = 1'b0; ack_gen = 1'b0; slave_sda = 1'b1;
    byte_complete = 1'b1; ack = ack_val;
    tick();
    byte_complete = 1'b0; ack = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(output logic stop_seen, output logic txr_seen);
    int n;
    logic ps, pc;
    n = 0; stop_seen = 1'b0; txr_seen = 1'b0; ps = sda_out; pc = scl_out;
    while (done !== 1'b1 && n < 200) begin
      tick(); n++;
      if (sda_out && !ps && scl_out && pc) stop_seen = 1'b1;
      if (tx_ready) txr_seen = 1'b1;
      ps = sda_out; pc = scl_out;
    end
    chk("done_pulse", done, 1);
  endtask

  logic [7:0] seen;
  logic       ack_sda, sn_seen, stop_seen, txr_seen;
  logic [7:0] wbytes [2];
  logic [7:0] rbytes [3];

  initial begin
    wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;
    rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;

    // Reset values
    repeat (3) tick();
    chk("reset_outputs", {sda_out, scl_out, busy, done, timer_active, direction, tx_ready,
                          rx_valid, should_nack, nack_err, arb_err}, 11'b11000100000);
    chk("reset_rx_data", rx_data, 8'h00);
    n_rst = 1'b1;
    tick();

    // Write 0x50, two bytes
    start_txn(1'b0, 7'h50, 6'd2);
    run_byte(1'b1, 8'h00, 1'b0, seen, ack_sda, sn_seen);
    chk("wr_addr_byte", seen, 8'hA0);
    chk("wr_addr_ack_release", ack_sda, 1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({24'd0, wbytes[i]});
      send_tx(wbytes[i]);
      chk("wr_direction_tx", direction, 1);
      run_byte(1'b1, 8'h00, 1'b0, seen, ack_sda, sn_seen);
      chk("wr_data_byte", seen, exp_q.pop_front());
      chk("wr_data_ack_release", ack_sda, 1);
    end
    wait_done(stop_seen, txr_seen);
    chk("wr_stop_condition", stop_seen, 1);
    chk("wr_nack_err", nack_err, 0);
    tick();
    chk("wr_done_one_cycle", {done, busy}, 2'b00);

    // Read 0x21, three bytes; master NACKs the last one
    start_txn(1'b1, 7'h21, 6'd3);
    run_byte(1'b1, 8'h00, 1'b0, seen, ack_sda, sn_seen);
    chk("rd_addr_byte", seen, 8'h43);
    chk("rd_addr_should_nack", sn_seen, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({24'd0, rbytes[i]});
      run_byte(1'b0, rbytes[i], 1'b0, seen, ack_sda, sn_seen);
      chk("rd_rx_valid", rx_valid, 1);
      chk("rd_rx_data", rx_data, exp_q.pop_front());
      chk("rd_should_nack", sn_seen, (i == 2) ? 1 : 0);
      chk("rd_master_ack_sda", ack_sda, (i == 2) ? 1 : 0);
      tick();
      chk("rd_rx_valid_one_cycle", rx_valid, 0);
    end
    wait_done(stop_seen, txr_seen);
    chk("rd_stop_condition", stop_seen, 1);
    tick();

    // Address NACK
    start_txn(1'b0, 7'h30, 6'd2);
    run_byte(1'b1, 8'h00, 1'b1, seen, ack_sda, sn_seen);
    chk("nak_nack_err_set", nack_err, 1);
    wait_done(stop_seen, txr_seen);
    chk("nak_no_tx_ready", txr_seen, 0);
    chk("nak_stop_condition", stop_seen, 1);
    tick();

    // Bus held busy, then abort during data byte 1
    force_sda_low = 1'b1;
    rw = 1'b0; addr = 7'h11; byte_count = 6'd1; go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_clears_nack", nack_err, 0);
    repeat (20) tick();
    chk("bus_busy_no_start", {sda_out, scl_out, busy}, 3'b111);
    force_sda_low = 1'b0;
    repeat (3) tick();
    chk("bus_free_wait", sda_out, 1);
    tick();
    chk("bus_free_start", {sda_out, scl_out}, 2'b01);
    run_byte(1'b1, 8'h00, 1'b0, seen, ack_sda, sn_seen);
    send_tx(8'h00);
    repeat (3) tick();
    chk("abt_data_sda_low", sda_out, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_err_lines", {sda_out, scl_out, timer_active, arb_err}, 4'b1101);
    tick();
    chk("abt_idle_sticky", {busy, arb_err}, 2'b01);

    // Next go clears arb_err; reset asserted in DATA
    start_txn(1'b0, 7'h7F, 6'd1);
    chk("go_clears_arb", arb_err, 0);
    run_byte(1'b1, 8'h00, 1'b0, seen, ack_sda, sn_seen);
    chk("rst_addr_byte", seen, 8'hFE);
    send_tx(8'h00);
    tick();
    chk("rst_pre_lines", {sda_out, scl_out, busy, timer_active}, 4'b0011);
    #1 n_rst = 1'b0;
    #1 chk("rst_async_outputs", {sda_out, scl_out, busy, done, timer_active, direction,
                                 tx_ready, rx_valid, should_nack, nack_err, arb_err},
                                11'b11000100000);
    tick();
    n_rst = 1'b1;
    tick();
    chk("rst_stays_idle", {busy, sda_out, scl_out}, 3'b011);

    // clock_div = 0 behaves as 1
    clock_div = 32'd0;
    rw = 1'b0; addr = 7'h01; byte_count = 6'd0; go = 1'b1;
    tick();
    go = 1'b0;
    chk("div0_bus_chk", sda_out, 1);
    tick();
    chk("div0_start_a", {sda_out, scl_out}, 2'b01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("div0_abort_idle", {busy, arb_err}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
